// File: rtl/spawn_scheduler.sv
// spawn_scheduler: decides when a new fruit/bomb object is launched, which
// idle slot receives it (round-robin), its kind and start column, and merges
// the per-slot hit/bomb pulses into the saturating game score.
module spawn_scheduler #(
  parameter int NSLOT      = 4,
  parameter int MIN_GAP    = 30,
  parameter int MAX_ACTIVE = 3,
  parameter int SCORE_MAX  = 9999,
  parameter int BOMB_KIND  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             tick,
  input  logic [31:0]      rand_word,
  input  logic [NSLOT-1:0] slot_idle,
  input  logic [NSLOT-1:0] hit,
  input  logic [NSLOT-1:0] bomb,
  output logic [NSLOT-1:0] launch,
  output logic [2:0]       launch_kind,
  output logic [9:0]       launch_x,
  output logic [3:0]       active_cnt,
  output logic [15:0]      score,
  output logic [7:0]       miss_cnt
);

  localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int GW = $clog2(MIN_GAP + 64) + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_GAP = 3'd1;
  localparam logic [2:0] S_PICK     = 3'd2;
  localparam logic [2:0] S_ISSUE    = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;

  localparam logic [GW-1:0]    GAP_MIN      = GW'(MIN_GAP);
  localparam logic [3:0]       ACTIVE_LIMIT = 4'(MAX_ACTIVE);
  localparam logic [16:0]      SCORE_CEIL   = 17'(SCORE_MAX);
  localparam logic [SW-1:0]    LAST_SLOT    = SW'(NSLOT - 1);
  localparam logic [NSLOT-1:0] ONE_HOT0     = NSLOT'(1);

  logic [2:0]       state_reg;
  logic [GW-1:0]    gap_reg;
  logic [SW-1:0]    sel_reg;
  logic [SW-1:0]    rr_ptr_reg;
  logic [1:0]       ack_cnt_reg;
  logic [NSLOT-1:0] launch_reg;
  logic [2:0]       kind_reg;
  logic [9:0]       x_reg;
  logic [15:0]      score_reg;
  logic [7:0]       miss_reg;
  logic [3:0]       active_reg;

  logic             pick_found;
  logic [SW-1:0]    pick_sel;
  logic             eligible;
  logic [9:0]       x_fold;
  logic [GW-1:0]    gap_reload;
  logic [NSLOT-1:0] eff_hit;
  logic [3:0]       n_hit;
  logic [3:0]       n_bomb;
  logic [3:0]       n_busy;
  logic [16:0]      score_sum;
  logic [16:0]      score_capped;
  logic [16:0]      bomb_penalty;
  logic [16:0]      score_next;

  // The kind code for bombs is interpreted by the motion slots, and rand bits
  // above the gap field are not needed here.
  logic unused_bits;
  assign unused_bits = ^{rand_word[31:16], (BOMB_KIND < 0)};

  // A bomb on a slot cancels a simultaneous hit on the same slot.
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_eff_hit
      assign eff_hit[gi] = hit[gi] & ~bomb[gi];
    end
  endgenerate

  // Popcounts of effective hits, bombs and busy slots.
  always_comb begin
    n_hit  = '0;
    n_bomb = '0;
    n_busy = '0;
    for (int i = 0; i < NSLOT; i++) begin
      n_hit  = n_hit  + {3'b000, eff_hit[i]};
      n_bomb = n_bomb + {3'b000, bomb[i]};
      n_busy = n_busy + {3'b000, ~slot_idle[i]};
    end
  end

  // Score update: add hits with saturation, then subtract 10 per bomb down to 0.
  always_comb begin
    score_sum    = {1'b0, score_reg} + {13'b0, n_hit};
    score_capped = (score_sum > SCORE_CEIL) ? SCORE_CEIL : score_sum;
    bomb_penalty = {13'b0, n_bomb} * 17'd10;
    score_next   = (score_capped >= bomb_penalty) ? (score_capped - bomb_penalty) : 17'd0;
  end

  // Round-robin search: first idle slot after rr_ptr, wrapping at NSLOT-1.
  // Scanning from the farthest offset down lets the nearest match win.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_sel   = '0;
    for (int k = NSLOT; k >= 1; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NSLOT) idx = idx - NSLOT;
      if (slot_idle[SW'(idx)]) begin
        pick_found = 1'b1;
        pick_sel   = SW'(idx);
      end
    end
  end

  assign eligible   = pick_found && (active_reg < ACTIVE_LIMIT);
  assign x_fold     = (rand_word[9:0] >= 10'd540) ? (rand_word[9:0] - 10'd540) : rand_word[9:0];
  assign gap_reload = GAP_MIN + GW'(rand_word[15:10]);

  // Launch sequencer: gap countdown, slot pick, one-cycle strobe, ack window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      gap_reg     <= '0;
      sel_reg     <= '0;
      rr_ptr_reg  <= LAST_SLOT;
      ack_cnt_reg <= '0;
      launch_reg  <= '0;
      kind_reg    <= '0;
      x_reg       <= '0;
      miss_reg    <= '0;
    end else begin
      launch_reg <= '0;
      case (state_reg)
        S_IDLE: begin
          if (run) begin
            gap_reg   <= GAP_MIN;
            state_reg <= S_WAIT_GAP;
          end
        end
        S_WAIT_GAP: begin
          if (!run) begin
            state_reg <= S_IDLE;
          end else if ((gap_reg == '0) || (tick && (gap_reg == GW'(1)))) begin
            gap_reg   <= '0;
            state_reg <= S_PICK;
          end else if (tick) begin
            gap_reg <= gap_reg - GW'(1);
          end
        end
        S_PICK: begin
          if (!run) begin
            state_reg <= S_IDLE;
          end else if (eligible) begin
            sel_reg    <= pick_sel;
            kind_reg   <= rand_word[2:0];
            x_reg      <= x_fold;
            launch_reg <= ONE_HOT0 << pick_sel;
            state_reg  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rr_ptr_reg  <= sel_reg;
          ack_cnt_reg <= '0;
          state_reg   <= S_ACK;
        end
        S_ACK: begin
          if (!slot_idle[sel_reg] || (ack_cnt_reg == 2'd3)) begin
            if (slot_idle[sel_reg] && (miss_reg != 8'hFF)) begin
              miss_reg <= miss_reg + 8'd1;
            end
            gap_reg   <= gap_reload;
            state_reg <= S_WAIT_GAP;
          end else begin
            ack_cnt_reg <= ack_cnt_reg + 2'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Score and busy-slot count run every cycle regardless of sequencer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      score_reg  <= '0;
      active_reg <= '0;
    end else begin
      score_reg  <= score_next[15:0];
      active_reg <= n_busy;
    end
  end

  assign launch      = launch_reg;
  assign launch_kind = kind_reg;
  assign launch_x    = x_reg;
  assign active_cnt  = active_reg;
  assign score       = score_reg;
  assign miss_cnt    = miss_reg;

endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: drives spawn_scheduler with directed and randomized
// stimulus and compares it with a behavioural model of the launch/score rules.
module tb_spawn_scheduler;

  localparam int NSLOT      = 4;
  localparam int MIN_GAP    = 2;
  localparam int MAX_ACTIVE = 3;
  localparam int SCORE_MAX  = 9999;

  logic             clk;
  logic             rst;
  logic             run;
  logic             tick;
  logic [31:0]      rand_word;
  logic [NSLOT-1:0] slot_idle;
  logic [NSLOT-1:0] hit;
  logic [NSLOT-1:0] bomb;
  logic [NSLOT-1:0] launch;
  logic [2:0]       launch_kind;
  logic [9:0]       launch_x;
  logic [3:0]       active_cnt;
  logic [15:0]      score;
  logic [7:0]       miss_cnt;

  int checks;
  int errors;

  // reference model state
  int               exp_score;
  int               exp_miss;
  int               last_sel;
  int               pend;
  int               pend_slot;
  int               tick_since;
  logic             prev_strobe;
  logic [NSLOT-1:0] idle_prev;
  logic             strobe_seen;

  // slot behaviour model
  int               life [NSLOT];
  logic [NSLOT-1:0] resp;
  int               life_len;
  logic             rand_life;
  logic             rand_resp;
  logic             rand_hold;
  logic             tick_en;

  spawn_scheduler #(
    .NSLOT(NSLOT), .MIN_GAP(MIN_GAP), .MAX_ACTIVE(MAX_ACTIVE),
    .SCORE_MAX(SCORE_MAX), .BOMB_KIND(2)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .tick(tick), .rand_word(rand_word),
    .slot_idle(slot_idle), .hit(hit), .bomb(bomb), .launch(launch),
    .launch_kind(launch_kind), .launch_x(launch_x), .active_cnt(active_cnt),
    .score(score), .miss_cnt(miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // tick pulse every 4 cycles, changed 2 time units after the edge
  initial begin
    int tc;
    tc   = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tick = tick_en && ((tc % 4) == 3);
      tc++;
    end
  end

  function automatic int fold_x(input int v);
    return (v >= 540) ? v - 540 : v;
  endfunction

  // One clock: check outputs against the model, then advance the slot model.
  task automatic step();
    int nh, nb, tmp, busy, es;
    logic found;
    logic [NSLOT-1:0] exp_vec;
    @(posedge clk);
    #1;
    strobe_seen = (launch != '0);
    if (rst) begin
      exp_score = 0; exp_miss = 0; last_sel = NSLOT - 1;
      pend = 0; tick_since = 0; prev_strobe = 1'b0;
      checks++;
      if (launch !== '0 || score !== 16'd0 || miss_cnt !== 8'd0 || active_cnt !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold launch=%b score=%0d miss=%0d active=%0d required all 0",
                 launch, score, miss_cnt, active_cnt);
      end
    end else begin
      nh = 0; nb = 0;
      for (int i = 0; i < NSLOT; i++) begin
        if (bomb[i]) nb++;
        else if (hit[i]) nh++;
      end
      tmp = exp_score + nh;
      if (tmp > SCORE_MAX) tmp = SCORE_MAX;
      exp_score = (tmp >= 10 * nb) ? tmp - 10 * nb : 0;
      checks++;
      if (score !== 16'(exp_score)) begin
        errors++;
        $display("FAIL score got %0d required %0d", score, exp_score);
      end
      busy = $countones(~slot_idle);
      checks++;
      if (active_cnt !== 4'(busy)) begin
        errors++;
        $display("FAIL active_cnt got %0d required %0d", active_cnt, busy);
      end
      if (pend == 1) pend = 2;
      else if (pend >= 2) begin
        if (!slot_idle[pend_slot]) pend = 0;
        else if (pend == 5) begin
          if (exp_miss < 255) exp_miss++;
          pend = 0;
        end else pend++;
      end
      checks++;
      if (miss_cnt !== 8'(exp_miss)) begin
        errors++;
        $display("FAIL miss_cnt got %0d required %0d", miss_cnt, exp_miss);
      end
      if (prev_strobe) begin
        checks++;
        if (launch !== '0) begin
          errors++;
          $display("FAIL strobe_width launch=%b required 0 after one cycle", launch);
        end
      end
      if (strobe_seen && !prev_strobe) begin
        found = 1'b0; es = 0;
        for (int k = 1; k <= NSLOT; k++) begin
          if (!found && slot_idle[(last_sel + k) % NSLOT]) begin
            found = 1'b1;
            es = (last_sel + k) % NSLOT;
          end
        end
        exp_vec = found ? (NSLOT'(1) << es) : '0;
        checks++;
        if (launch !== exp_vec) begin
          errors++;
          $display("FAIL launch_slot got %b required %b", launch, exp_vec);
        end
        checks++;
        if (launch_kind !== rand_word[2:0]) begin
          errors++;
          $display("FAIL launch_kind got %0d required %0d", launch_kind, rand_word[2:0]);
        end
        checks++;
        if (launch_x !== 10'(fold_x(int'(rand_word[9:0])))) begin
          errors++;
          $display("FAIL launch_x got %0d required %0d", launch_x, fold_x(int'(rand_word[9:0])));
        end
        checks++;
        if ($countones(~idle_prev) >= MAX_ACTIVE) begin
          errors++;
          $display("FAIL launch_limit busy=%0d required below %0d", $countones(~idle_prev), MAX_ACTIVE);
        end
        checks++;
        if (tick_since < MIN_GAP) begin
          errors++;
          $display("FAIL launch_gap ticks=%0d required at least %0d", tick_since, MIN_GAP);
        end
        last_sel = es; pend = 1; pend_slot = es; tick_since = 0;
      end else if (tick) begin
        tick_since++;
      end
      prev_strobe = strobe_seen;
    end
    idle_prev = slot_idle;
    for (int i = 0; i < NSLOT; i++) begin
      if (life[i] > 0) begin
        life[i]--;
        if (life[i] == 0) slot_idle[i] = 1'b1;
      end
    end
    if (strobe_seen && !rst) begin
      for (int s = 0; s < NSLOT; s++) begin
        if (launch[s] && (rand_resp ? ($urandom_range(0, 9) != 0) : resp[s])) begin
          slot_idle[s] = 1'b0;
          life[s] = rand_life ? int'($urandom_range(6, 40)) : ((life_len == 0) ? -1 : life_len);
        end
      end
    end
    if (!rand_hold) rand_word = $urandom;
  endtask

  task automatic wait_strobe(input int budget, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!strobe_seen && n < budget);
    checks++;
    if (!strobe_seen) begin
      errors++;
      $display("FAIL %s no launch within %0d cycles, required one", name, budget);
    end
  endtask

  task automatic count_strobes(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (strobe_seen) cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; hit = '0; bomb = '0;
    slot_idle = '1;
    for (int i = 0; i < NSLOT; i++) life[i] = 0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; slot_idle = '0; hit = '1; bomb = '0;
    repeat (3) step();
    checks++;
    if (launch_kind !== 3'd0 || launch_x !== 10'd0) begin
      errors++;
      $display("FAIL reset_kind_x kind=%0d x=%0d required 0 0", launch_kind, launch_x);
    end
    rst = 1'b0; hit = '0; slot_idle = 4'b1010;
    step();
    checks++;
    if (active_cnt !== 4'd2) begin
      errors++;
      $display("FAIL active_lag got %0d required 2", active_cnt);
    end
    slot_idle = '1;
    step();
  endtask

  task automatic test_first_launch_and_rotation();
    int cnt;
    do_reset();
    rand_hold = 1'b1; rand_word = 32'h1234_0258;
    life_len = 0; resp = '1; rand_resp = 1'b0; rand_life = 1'b0;
    run = 1'b1;
    wait_strobe(60, "first_launch");
    checks++;
    if (launch !== 4'b0001 || launch_x !== 10'd60 || launch_kind !== 3'd0) begin
      errors++;
      $display("FAIL first_launch launch=%b x=%0d kind=%0d required 0001 60 0", launch, launch_x, launch_kind);
    end
    wait_strobe(60, "rotate_1");
    checks++;
    if (launch !== 4'b0010) begin
      errors++;
      $display("FAIL rotate_1 launch=%b required 0010", launch);
    end
    wait_strobe(60, "rotate_2");
    checks++;
    if (launch !== 4'b0100) begin
      errors++;
      $display("FAIL rotate_2 launch=%b required 0100", launch);
    end
    count_strobes(120, cnt);
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL withheld launches=%0d required 0", cnt);
    end
    life[0] = 0; slot_idle[0] = 1'b1;
    wait_strobe(60, "after_free");
    checks++;
    if (launch !== 4'b1000) begin
      errors++;
      $display("FAIL after_free launch=%b required 1000", launch);
    end
    run = 1'b0;
  endtask

  task automatic test_x_fold();
    int vals [4];
    int exp_x [4];
    vals = '{539, 540, 1023, 0};
    exp_x = '{539, 0, 483, 0};
    do_reset();
    rand_hold = 1'b1; life_len = 12; resp = '1; rand_resp = 1'b0; rand_life = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_word = 32'hA5A5_0000 | 32'(vals[i]);
      wait_strobe(80, "x_fold");
      checks++;
      if (launch_x !== 10'(exp_x[i]) || launch_kind !== 3'(vals[i] % 8)) begin
        errors++;
        $display("FAIL x_fold rand=%0d x=%0d kind=%0d required %0d %0d",
                 vals[i], launch_x, launch_kind, exp_x[i], vals[i] % 8);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_miss();
    do_reset();
    rand_hold = 1'b1; rand_word = 32'h0; life_len = 0; resp = 4'b1110;
    rand_resp = 1'b0; rand_life = 1'b0;
    run = 1'b1;
    wait_strobe(60, "miss_launch");
    repeat (8) step();
    checks++;
    if (miss_cnt !== 8'd1) begin
      errors++;
      $display("FAIL miss_count got %0d required 1", miss_cnt);
    end
    wait_strobe(60, "miss_next");
    checks++;
    if (launch !== 4'b0010) begin
      errors++;
      $display("FAIL miss_skip launch=%b required 0010", launch);
    end
    run = 1'b0;
  endtask

  task automatic test_run_drop();
    int cnt;
    do_reset();
    rand_hold = 1'b0; life_len = 10; resp = '1; rand_resp = 1'b0; rand_life = 1'b0;
    run = 1'b1;
    wait_strobe(400, "drop_wait_launch");
    repeat (2) step();
    run = 1'b0;
    count_strobes(300, cnt);
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL drop_wait launches=%0d required 0", cnt);
    end
    resp = '0;
    run = 1'b1;
    wait_strobe(400, "drop_issue_launch");
    run = 1'b0;
    repeat (10) step();
    checks++;
    if (miss_cnt !== 8'd1) begin
      errors++;
      $display("FAIL drop_issue_ack miss=%0d required 1", miss_cnt);
    end
    count_strobes(300, cnt);
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL drop_issue launches=%0d required 0", cnt);
    end
  endtask

  task automatic test_score();
    do_reset();
    hit = 4'b1111; step();
    hit = 4'b0001; step();
    checks++;
    if (score !== 16'd5) begin
      errors++;
      $display("FAIL score_5 got %0d required 5", score);
    end
    hit = 4'b0011; bomb = 4'b0100; step();
    checks++;
    if (score !== 16'd0) begin
      errors++;
      $display("FAIL score_floor got %0d required 0", score);
    end
    bomb = '0;
    repeat (2499) begin
      hit = 4'b1111; step();
    end
    hit = 4'b0011; step();
    checks++;
    if (score !== 16'd9998) begin
      errors++;
      $display("FAIL score_9998 got %0d required 9998", score);
    end
    hit = 4'b1111; step();
    checks++;
    if (score !== 16'd9999) begin
      errors++;
      $display("FAIL score_sat got %0d required 9999", score);
    end
    step();
    checks++;
    if (score !== 16'd9999) begin
      errors++;
      $display("FAIL score_sat_hold got %0d required 9999", score);
    end
    hit = '0;
    do_reset();
    repeat (5) begin
      hit = 4'b1111; step();
    end
    hit = 4'b0001; bomb = 4'b0001; step();
    checks++;
    if (score !== 16'd10) begin
      errors++;
      $display("FAIL score_bomb_wins got %0d required 10", score);
    end
    hit = '0; bomb = '0;
  endtask

  task automatic test_rst_mid();
    do_reset();
    repeat (10) begin
      hit = 4'b1111; step();
    end
    hit = 4'b0011; step();
    hit = '0;
    checks++;
    if (score !== 16'd42) begin
      errors++;
      $display("FAIL score_42 got %0d required 42", score);
    end
    rand_hold = 1'b1; rand_word = 32'h0; life_len = 10; resp = '0;
    rand_resp = 1'b0; rand_life = 1'b0;
    run = 1'b1;
    wait_strobe(60, "rst_ack_launch");
    repeat (2) step();
    rst = 1'b1;
    step();
    checks++;
    if (launch !== '0 || score !== 16'd0 || miss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_ack launch=%b score=%0d miss=%0d required 0 0 0", launch, score, miss_cnt);
    end
    rst = 1'b0; resp = '1;
    wait_strobe(60, "rst_issue_launch");
    rst = 1'b1;
    step();
    checks++;
    if (launch !== '0) begin
      errors++;
      $display("FAIL rst_mid_issue launch=%b required 0", launch);
    end
    rst = 1'b0; run = 1'b0;
  endtask

  task automatic test_random();
    int cnt;
    do_reset();
    rand_hold = 1'b0; rand_life = 1'b1; rand_resp = 1'b1;
    run = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      hit  = (($urandom % 4) == 0) ? NSLOT'($urandom) : '0;
      bomb = (($urandom % 8) == 0) ? NSLOT'($urandom) : '0;
      if (($urandom % 300) == 0) run = ~run;
      step();
      if (strobe_seen) cnt++;
    end
    hit = '0; bomb = '0; run = 1'b0;
    checks++;
    if (cnt < 3) begin
      errors++;
      $display("FAIL random_liveness launches=%0d required at least 3", cnt);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; run = 1'b0; hit = '0; bomb = '0; slot_idle = '1;
    rand_word = 32'h0; tick_en = 1'b1;
    resp = '1; life_len = 0; rand_life = 1'b0; rand_resp = 1'b0; rand_hold = 1'b1;
    for (int i = 0; i < NSLOT; i++) life[i] = 0;
    exp_score = 0; exp_miss = 0; last_sel = NSLOT - 1; pend = 0; pend_slot = 0;
    tick_since = 0; prev_strobe = 1'b0; idle_prev = '1; strobe_seen = 1'b0;
    test_reset();
    test_first_launch_and_rotation();
    test_x_fold();
    test_miss();
    test_run_drop();
    test_score();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spawn_scheduler.md
# spawn_scheduler

Sequences the fruit/bomb object slots of the game field: decides when a new object is launched, which idle slot receives it, and with what kind and start column. It also merges per-slot hit and bomb events into the single game score. Sits between the random number generator, the mouse/collision logic and NSLOT object-motion slots, and replaces per-slot self-restart logic.

## Interface
- NSLOT, 4: number of object slots (2..8).
- MIN_GAP, 30: minimum ticks between consecutive launches.
- MAX_ACTIVE, 3: maximum simultaneously busy slots (1..NSLOT).
- SCORE_MAX, 9999: score saturation ceiling.
- BOMB_KIND, 2: kind code treated as a bomb.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  game running; 0 inhibits new launches.
- tick  in  1  one-cycle pulse per motion frame (moveclk domain already synchronized).
- rand  in  32  free-running LFSR output, sampled as needed.
- slot_idle  in  NSLOT  1 = slot has no object in flight (out of bounds / never launched).
- hit  in  NSLOT  one-cycle pulse: fruit in slot sliced.
- bomb  in  NSLOT  one-cycle pulse: bomb in slot sliced.
- launch  out  NSLOT  one-hot, one-cycle launch strobe.
- launch_kind  out  3  object kind for the strobed slot.
- launch_x  out  10  start column, 0..539.
- active_cnt  out  4  popcount of ~slot_idle, registered.
- score  out  16  current score.
- miss_cnt  out  8  launches not acknowledged, saturating at 255.

## Operation
- States: IDLE, WAIT_GAP, PICK, ISSUE, ACK.
- IDLE: launch=0. When run=1: gap counter <= MIN_GAP, go WAIT_GAP.
- WAIT_GAP: gap counter decrements by 1 on each tick; at 0 go PICK. run=0 -> IDLE.
- PICK: eligible if active_cnt < MAX_ACTIVE and at least one slot idle. Select first idle slot searching round-robin from rr_ptr+1 (wrapping NSLOT-1 -> 0). Register sel, launch_kind <= rand[2:0], launch_x <= rand[9:0] minus 540 if rand[9:0] >= 540 else rand[9:0]. Go ISSUE. Not eligible: stay in PICK, re-evaluate every cycle. run=0 -> IDLE.
- ISSUE: launch[sel]=1 for exactly this cycle; rr_ptr <= sel; go ACK. run is ignored.
- ACK: wait for slot_idle[sel]=0. Seen within 4 cycles (counting from the first ACK cycle) -> load gap counter with MIN_GAP + rand[15:10], go WAIT_GAP. Not seen -> miss_cnt += 1 (saturating), same gap load, go WAIT_GAP.
- launch_kind and launch_x hold their values from PICK until the next PICK.
- Score (every cycle, independent of state): per slot, if hit and bomb both set, bomb wins. n_hit = popcount of effective hits, n_bomb = popcount of bombs. tmp = min(SCORE_MAX, score + n_hit); score <= tmp >= 10*n_bomb ? tmp - 10*n_bomb : 0. Arithmetic is 17-bit internal, with no wrap.
- active_cnt is updated every cycle from slot_idle.

## Timing
- Reset values: state IDLE, launch 0, launch_kind 0, launch_x 0, score 0, miss_cnt 0, active_cnt 0, rr_ptr NSLOT-1 (first pick is slot 0), gap counter 0.
- rst takes priority over every event. If rst is asserted mid-ISSUE, launch is 0 on the following cycle.
- Minimum latency: run rise to first launch strobe = 2 + MIN_GAP ticks + 1 cycle.
- Minimum launch spacing is MIN_GAP ticks. A tick in ACK or PICK is not counted.
- score reflects hit/bomb pulses one cycle after the pulse. active_cnt lags slot_idle by one cycle, and PICK uses this registered value.
- Simultaneous tick and counter reaching 0 to PICK: PICK is entered on the next cycle.

## Test plan
- Reset then run=1, all slots idle, MIN_GAP=2, tick every 4 cycles -> launch=4'b0001 after 2 ticks. launch_x = rand[9:0] mod-540 rule, e.g. rand[9:0]=600 -> 60.
- Slots acknowledge each launch; repeated launches -> strobes rotate 0001, 0010, 0100. The 4th is withheld while active_cnt=3 and is issued to slot 3 once any slot goes idle.
- Slot never deasserts idle after launch -> miss_cnt increments to 1 after 4 ACK cycles. The scheduler continues to WAIT_GAP, and the next pick skips to the following slot.
- score=5, hit=4'b0011 and bomb=4'b0100 in one cycle -> score 0. score=9998 with hit=4'b1111 -> 9999. hit and bomb on same slot with score=20 -> 10.
- run dropped in WAIT_GAP -> IDLE, no further strobes. run dropped during ISSUE -> strobe completes, ACK completes, then IDLE after WAIT_GAP sees run=0.
- rst asserted mid-ACK with score=42 -> the next cycle shows state IDLE, score 0, launch 0, miss_cnt 0.
